rgb_rd_arbiter: RTL and testbench

- Shares the single host RGB image-memory read port (req/addr/ready/24-bit data) between two on-chip requesters.
- Requester 0 is the gray-conversion fetch path. Requester 1 is an auxiliary reader, e.g. a preview or histogram engine.
- Round-robin arbitration, one transaction in flight at a time.
- Read data is routed back only to the requester that owns the transaction.

---
 rtl/rgb_rd_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_rgb_rd_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_rd_arbiter.sv
// -----------------------------------------------------------------------------
// rgb_rd_arbiter
//
// Purpose:
//   Shares the single host RGB image-memory read port between two on-chip
//   requesters. Requester 0 is the gray-conversion fetch path. Requester 1 is
//   an auxiliary reader, such as a preview or histogram engine.
//   Only one transaction is in flight at a time. Read data is steered back
//   only to the requester that owns the current transaction.
//
// Arbitration:
//   Round-robin by default. When both requesters ask at once, the one that
//   was not granted last wins. The last-grant pointer resets to 1, so
//   requester 0 wins the first tie.
//   Build option RGB_ARB_FIXED_PRIO_EN: when this macro is defined, requester 0
//   always wins a tie. The pointer is still updated but is not consulted.
//
// Transaction timing (edges E0..E3):
//   E0 : req sampled in ARB; gnt/mem_req/mem_addr registered  (-> ISSUE)
//   E1 : gnt/mem_req dropped                                   (-> CAPT)
//   E2 : mem_data captured into the owner's rdata, rvalid set  (-> RET)
//   E3 : rvalid dropped                                        (-> ARB)
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-high reset
//   mem_ready   in   host memory available (level)
//   mem_req     out  one-cycle read strobe to host memory
//   mem_addr    out  read address, valid while mem_req=1
//   mem_data    in   read data, valid in the cycle after mem_req=1
//   rqN_req     in   requester N read request, held until granted
//   rqN_addr    in   requester N address, stable while rqN_req=1
//   rqN_gnt     out  one-cycle pulse: request N accepted
//   rqN_rvalid  out  one-cycle pulse: rqN_rdata valid
//   rqN_rdata   out  read data for requester N (holds between deliveries)
//   busy        out  transaction in flight (ISSUE, CAPT or RET)
//
// All outputs are driven directly from flops.
// -----------------------------------------------------------------------------
module rgb_rd_arbiter #(
    parameter int AW = 14,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_ready,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          rq0_req,
    input  logic [AW-1:0] rq0_addr,
    output logic          rq0_gnt,
    output logic          rq0_rvalid,
    output logic [DW-1:0] rq0_rdata,
    input  logic          rq1_req,
    input  logic [AW-1:0] rq1_addr,
    output logic          rq1_gnt,
    output logic          rq1_rvalid,
    output logic [DW-1:0] rq1_rdata,
    output logic          busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RET   = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;

    // Arbitration bookkeeping
    logic            ptr_r;        // requester granted last
    logic            ptr_s;
    logic            owner_r;      // requester owning the in-flight transaction
    logic            owner_s;
    logic            win_valid_s;  // at least one request is pending
    logic            win_s;        // index of the winning requester

    // Output registers and their next values
    logic            mem_req_r;
    logic            mem_req_s;
    logic [AW-1:0]   mem_addr_r;
    logic [AW-1:0]   mem_addr_s;
    logic            gnt0_r;
    logic            gnt0_s;
    logic            gnt1_r;
    logic            gnt1_s;
    logic            rvalid0_r;
    logic            rvalid0_s;
    logic            rvalid1_r;
    logic            rvalid1_s;
    logic [DW-1:0]   rdata0_r;
    logic [DW-1:0]   rdata0_s;
    logic [DW-1:0]   rdata1_r;
    logic [DW-1:0]   rdata1_s;
    logic            busy_r;
    logic            busy_s;

    // Winner selection from the current request lines and last-grant pointer
    always_comb begin
        win_valid_s = 1'b0;
        win_s       = 1'b0;
        if (rq0_req && rq1_req) begin
            win_valid_s = 1'b1;
`ifdef RGB_ARB_FIXED_PRIO_EN
            win_s       = 1'b0;
`else
            win_s       = ~ptr_r;
`endif
        end else if (rq0_req) begin
            win_valid_s = 1'b1;
            win_s       = 1'b0;
        end else if (rq1_req) begin
            win_valid_s = 1'b1;
            win_s       = 1'b1;
        end else begin
            win_valid_s = 1'b0;
            win_s       = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_ready) begin
                    state_s = ST_ARB;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (!mem_ready) begin
                    state_s = ST_IDLE;
                end else if (win_valid_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_ARB;
                end
            end
            ST_ISSUE: state_s = ST_CAPT;
            ST_CAPT:  state_s = ST_RET;
            // A mem_ready drop during the transaction is seen back in ARB.
            ST_RET:   state_s = ST_ARB;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Next values of all registered outputs and of the pointer/owner
    always_comb begin
        mem_req_s  = 1'b0;
        mem_addr_s = mem_addr_r;
        gnt0_s     = 1'b0;
        gnt1_s     = 1'b0;
        rvalid0_s  = 1'b0;
        rvalid1_s  = 1'b0;
        rdata0_s   = rdata0_r;
        rdata1_s   = rdata1_r;
        owner_s    = owner_r;
        ptr_s      = ptr_r;
        busy_s     = (state_s == ST_ISSUE) || (state_s == ST_CAPT) ||
                     (state_s == ST_RET);
        case (state_r)
            ST_ARB: begin
                if (mem_ready && win_valid_s) begin
                    mem_req_s = 1'b1;
                    owner_s   = win_s;
                    ptr_s     = win_s;
                    if (win_s) begin
                        gnt1_s     = 1'b1;
                        mem_addr_s = rq1_addr;
                    end else begin
                        gnt0_s     = 1'b1;
                        mem_addr_s = rq0_addr;
                    end
                end else begin
                    mem_req_s = 1'b0;
                end
            end
            ST_CAPT: begin
                // Only the owner's data register is loaded; the other holds.
                if (owner_r) begin
                    rdata1_s  = mem_data;
                    rvalid1_s = 1'b1;
                end else begin
                    rdata0_s  = mem_data;
                    rvalid0_s = 1'b1;
                end
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    // Output, pointer and owner registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_r  <= 1'b0;
            mem_addr_r <= {AW{1'b0}};
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            rvalid0_r  <= 1'b0;
            rvalid1_r  <= 1'b0;
            rdata0_r   <= {DW{1'b0}};
            rdata1_r   <= {DW{1'b0}};
            busy_r     <= 1'b0;
            owner_r    <= 1'b0;
            ptr_r      <= 1'b1;
        end else begin
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
            gnt0_r     <= gnt0_s;
            gnt1_r     <= gnt1_s;
            rvalid0_r  <= rvalid0_s;
            rvalid1_r  <= rvalid1_s;
            rdata0_r   <= rdata0_s;
            rdata1_r   <= rdata1_s;
            busy_r     <= busy_s;
            owner_r    <= owner_s;
            ptr_r      <= ptr_s;
        end
    end

    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign rq0_gnt    = gnt0_r;
    assign rq1_gnt    = gnt1_r;
    assign rq0_rvalid = rvalid0_r;
    assign rq1_rvalid = rvalid1_r;
    assign rq0_rdata  = rdata0_r;
    assign rq1_rdata  = rdata1_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_rgb_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rgb_rd_arbiter
//
// Directed scenarios for reset, latency, round-robin order, mem_ready
// handling and reset mid-transaction, followed by randomized traffic from
// two requester agents checked against a transaction-level model.
// Outputs are sampled on the falling edge; inputs change right after.
// Define RGB_ARB_FIXED_PRIO_EN for both bench and RTL to exercise the
// fixed-priority build.
// -----------------------------------------------------------------------------
module tb_rgb_rd_arbiter;

    localparam int AW = 14;
    localparam int DW = 24;
    localparam int NC = 400;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic          rq0_req = 1'b0;
    logic [AW-1:0] rq0_addr = '0;
    logic          rq0_gnt;
    logic          rq0_rvalid;
    logic [DW-1:0] rq0_rdata;
    logic          rq1_req = 1'b0;
    logic [AW-1:0] rq1_addr = '0;
    logic          rq1_gnt;
    logic          rq1_rvalid;
    logic [DW-1:0] rq1_rdata;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // {gnt0, gnt1, mem_req, rvalid0, rvalid1, busy}
    logic [5:0] st;
    assign st = {rq0_gnt, rq1_gnt, mem_req, rq0_rvalid, rq1_rvalid, busy};

    // Expected per-cycle events for the random test
    logic [1:0]    exp_gnt  [0:NC+7];
    logic          exp_mr   [0:NC+7];
    logic [AW-1:0] exp_addr [0:NC+7];
    logic [1:0]    exp_rv   [0:NC+7];
    logic [DW-1:0] exp_d    [0:NC+7];
    logic          exp_busy [0:NC+7];

    rgb_rd_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .rq0_req(rq0_req), .rq0_addr(rq0_addr), .rq0_gnt(rq0_gnt),
        .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata),
        .rq1_req(rq1_req), .rq1_addr(rq1_addr), .rq1_gnt(rq1_gnt),
        .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        reset = 1'b1; mem_ready = rdy;
        rq0_req = 1'b0; rq1_req = 1'b0;
        rq0_addr = '0; rq1_addr = '0; mem_data = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        mem_ready = 1'b1; rq0_req = 1'b1; rq1_req = 1'b1;
        rq0_addr = 14'h0011; rq1_addr = 14'h0022; mem_data = 24'hABCDEF;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (st !== 6'b000000) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=%b", st, 6'b000000);
        end
        checks++;
        if (mem_addr !== 14'h0000) begin
            errors++; $display("FAIL reset_addr got=%h exp=0000", mem_addr);
        end
        checks++;
        if ({rq0_rdata, rq1_rdata} !== 48'h0) begin
            errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", rq0_rdata, rq1_rdata);
        end
        reset = 1'b0; mem_ready = 1'b0; rq0_req = 1'b0; rq1_req = 1'b0;
        @(negedge clk);
        checks++;
        if (st !== 6'b000000) begin
            errors++; $display("FAIL idle_after_reset got=%b exp=%b", st, 6'b000000);
        end
    endtask

    task automatic test_single_rq0;
        do_reset(1'b1);
        @(negedge clk);
        checks++;
        if (st !== 6'b000000) begin
            errors++; $display("FAIL single_pre got=%b exp=000000", st);
        end
        rq0_req = 1'b1; rq0_addr = 14'h0005; mem_data = 24'h123123;
        @(negedge clk);
        checks++;
        if (st !== 6'b101001) begin
            errors++; $display("FAIL single_gnt got=%b exp=101001", st);
        end
        checks++;
        if (mem_addr !== 14'h0005) begin
            errors++; $display("FAIL single_addr got=%h exp=0005", mem_addr);
        end
        rq0_req = 1'b0; rq0_addr = 14'h2AAA; mem_data = 24'h0F0F0F;
        @(negedge clk);
        checks++;
        if (st !== 6'b000001) begin
            errors++; $display("FAIL single_capt got=%b exp=000001", st);
        end
        mem_data = 24'hFF8040;
        @(negedge clk);
        checks++;
        if (st !== 6'b000101) begin
            errors++; $display("FAIL single_rvalid got=%b exp=000101", st);
        end
        checks++;
        if (rq0_rdata !== 24'hFF8040 || rq1_rdata !== 24'h000000) begin
            errors++; $display("FAIL single_rdata got=%h/%h exp=ff8040/000000", rq0_rdata, rq1_rdata);
        end
        mem_data = 24'h111111;
        @(negedge clk);
        checks++;
        if (st !== 6'b000000 || rq0_rdata !== 24'hFF8040) begin
            errors++; $display("FAIL single_done got=%b/%h exp=000000/ff8040", st, rq0_rdata);
        end
    endtask

    task automatic test_round_robin;
        logic          own;
        logic [5:0]    exp_st;
        logic [DW-1:0] got;
        do_reset(1'b1);
        @(negedge clk);
        rq0_req = 1'b1; rq0_addr = 14'h0010;
        rq1_req = 1'b1; rq1_addr = 14'h0020;
        mem_data = DW'($urandom);
        for (int k = 2; k < 18; k++) begin
            @(negedge clk);
`ifdef RGB_ARB_FIXED_PRIO_EN
            own = 1'b0;
`else
            own = ((k - 2) / 4) % 2 == 1;
`endif
            case ((k - 2) % 4)
                0:       exp_st = {!own, own, 1'b1, 1'b0, 1'b0, 1'b1};
                1:       exp_st = 6'b000001;
                2:       exp_st = {1'b0, 1'b0, 1'b0, !own, own, 1'b1};
                default: exp_st = 6'b000000;
            endcase
            checks++;
            if (st !== exp_st) begin
                errors++; $display("FAIL rr_ctrl cyc=%0d got=%b exp=%b", k, st, exp_st);
            end
            if ((k - 2) % 4 == 0) begin
                checks++;
                if (mem_addr !== (own ? 14'h0020 : 14'h0010)) begin
                    errors++; $display("FAIL rr_addr cyc=%0d got=%h exp=%h", k, mem_addr, own ? 14'h0020 : 14'h0010);
                end
            end
            if ((k - 2) % 4 == 2) begin
                got = own ? rq1_rdata : rq0_rdata;
                checks++;
                if (got !== mem_data) begin
                    errors++; $display("FAIL rr_rdata cyc=%0d got=%h exp=%h", k, got, mem_data);
                end
            end
            mem_data = DW'($urandom);
        end
        rq0_req = 1'b0; rq1_req = 1'b0;
    endtask

    task automatic test_ready_low;
        do_reset(1'b0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (st !== 6'b000000) begin
                errors++; $display("FAIL notready_quiet cyc=%0d got=%b exp=000000", i, st);
            end
            rq1_req = 1'b1; rq1_addr = 14'h0123;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (st !== 6'b000000) begin
            errors++; $display("FAIL ready_rise_arb got=%b exp=000000", st);
        end
        @(negedge clk);
        checks++;
        if (st !== 6'b011001 || mem_addr !== 14'h0123) begin
            errors++; $display("FAIL ready_rise_gnt got=%b/%h exp=011001/0123", st, mem_addr);
        end
        rq1_req = 1'b0;
        @(negedge clk);
        mem_data = 24'hC0FFEE;
        @(negedge clk);
        checks++;
        if (st !== 6'b000011 || rq1_rdata !== 24'hC0FFEE) begin
            errors++; $display("FAIL ready_rise_rvalid got=%b/%h exp=000011/c0ffee", st, rq1_rdata);
        end
    endtask

    task automatic test_reset_mid;
        do_reset(1'b1);
        @(negedge clk);
        rq0_req = 1'b1; rq0_addr = 14'h1234;
        @(negedge clk);
        checks++;
        if (st !== 6'b101001) begin
            errors++; $display("FAIL rstmid_gnt got=%b exp=101001", st);
        end
        rq0_req = 1'b0;
        @(negedge clk);
        mem_data = 24'hDEAD00;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (st !== 6'b000000 || rq0_rdata !== 24'h0 || mem_addr !== 14'h0) begin
            errors++; $display("FAIL rstmid_clear got=%b/%h/%h exp=000000/0/0", st, rq0_rdata, mem_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (st !== 6'b000000) begin
            errors++; $display("FAIL rstmid_no_rvalid got=%b exp=000000", st);
        end
        rq0_req = 1'b1; rq0_addr = 14'h3FFF;
        @(negedge clk);
        checks++;
        if (st !== 6'b101001 || mem_addr !== 14'h3FFF) begin
            errors++; $display("FAIL rstmid_regnt got=%b/%h exp=101001/3fff", st, mem_addr);
        end
        rq0_req = 1'b0;
        @(negedge clk);
        mem_data = 24'h123456;
        @(negedge clk);
        checks++;
        if (st !== 6'b000101 || rq0_rdata !== 24'h123456) begin
            errors++; $display("FAIL rstmid_done got=%b/%h exp=000101/123456", st, rq0_rdata);
        end
    endtask

    task automatic test_ready_drop;
        do_reset(1'b1);
        @(negedge clk);
        rq1_req = 1'b1; rq1_addr = 14'h0042;
        @(negedge clk);
        checks++;
        if (st !== 6'b011001) begin
            errors++; $display("FAIL drop_gnt got=%b exp=011001", st);
        end
        rq1_req = 1'b0; mem_ready = 1'b0; mem_data = 24'hABCDEF;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (st !== 6'b000011 || rq1_rdata !== 24'hABCDEF) begin
            errors++; $display("FAIL drop_rvalid got=%b/%h exp=000011/abcdef", st, rq1_rdata);
        end
        rq0_req = 1'b1; rq0_addr = 14'h0007;
        for (int i = 5; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (st !== 6'b000000) begin
                errors++; $display("FAIL drop_quiet cyc=%0d got=%b exp=000000", i, st);
            end
        end
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (st !== 6'b101001 || mem_addr !== 14'h0007) begin
            errors++; $display("FAIL drop_resume got=%b/%h exp=101001/0007", st, mem_addr);
        end
        rq0_req = 1'b0;
    endtask

    task automatic test_random;
        int   free_at;
        int   cap_c;
        logic cap_own;
        logic last;
        logic w;
        logic [DW-1:0] cur0;
        logic [DW-1:0] cur1;
        logic [5:0] exp_st;
        for (int i = 0; i < NC + 8; i++) begin
            exp_gnt[i] = 2'b00; exp_mr[i] = 1'b0; exp_addr[i] = '0;
            exp_rv[i] = 2'b00; exp_d[i] = '0; exp_busy[i] = 1'b0;
        end
        do_reset(1'b1);
        @(negedge clk);
        @(negedge clk);
        free_at = 0; cap_c = -1; cap_own = 1'b0; last = 1'b1;
        cur0 = '0; cur1 = '0;
        for (int c = 0; c < NC; c++) begin
            if (c > 0) @(negedge clk);
            exp_st = {exp_gnt[c][0], exp_gnt[c][1], exp_mr[c],
                      exp_rv[c][0], exp_rv[c][1], exp_busy[c]};
            checks++;
            if (st !== exp_st) begin
                errors++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", c, st, exp_st);
            end
            if (exp_mr[c]) begin
                checks++;
                if (mem_addr !== exp_addr[c]) begin
                    errors++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", c, mem_addr, exp_addr[c]);
                end
            end
            if (exp_rv[c][0]) cur0 = exp_d[c];
            if (exp_rv[c][1]) cur1 = exp_d[c];
            checks++;
            if (rq0_rdata !== cur0 || rq1_rdata !== cur1) begin
                errors++; $display("FAIL rand_rdata cyc=%0d got=%h/%h exp=%h/%h", c, rq0_rdata, rq1_rdata, cur0, cur1);
            end
            // Requester agents
            if (rq0_req && rq0_gnt) begin
                rq0_req = ($urandom % 2) == 0;
                rq0_addr = AW'($urandom);
            end else if (!rq0_req && ($urandom % 100) < 40) begin
                rq0_req = 1'b1;
                rq0_addr = AW'($urandom);
            end
            if (rq1_req && rq1_gnt) begin
                rq1_req = ($urandom % 2) == 0;
                rq1_addr = AW'($urandom);
            end else if (!rq1_req && ($urandom % 100) < 40) begin
                rq1_req = 1'b1;
                rq1_addr = AW'($urandom);
            end
            mem_data = DW'($urandom);
            // Transaction-level model
            if (c == cap_c) begin
                exp_rv[c+1][cap_own] = 1'b1;
                exp_d[c+1] = mem_data;
            end
            if (c >= free_at && (rq0_req || rq1_req)) begin
                if (rq0_req && rq1_req) begin
`ifdef RGB_ARB_FIXED_PRIO_EN
                    w = 1'b0;
`else
                    w = !last;
`endif
                end else begin
                    w = rq1_req;
                end
                exp_gnt[c+1][w] = 1'b1;
                exp_mr[c+1] = 1'b1;
                exp_addr[c+1] = w ? rq1_addr : rq0_addr;
                exp_busy[c+1] = 1'b1; exp_busy[c+2] = 1'b1; exp_busy[c+3] = 1'b1;
                cap_c = c + 2; cap_own = w; last = w;
                free_at = c + 4;
            end
        end
        rq0_req = 1'b0; rq1_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_rq0();
        test_round_robin();
        test_ready_low();
        test_reset_mid();
        test_ready_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
